fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID decode register. It owns the program counter and runs a request/ready handshake to a variable-latency instruction memory. It delivers one instruction per cycle with its PC+4 to decode, honours stall requests from the hazard logic, and flushes and redirects on branch/jump resolution.

## Interface
- PC_W, 9, program-counter / instruction-address width (byte address)
- INSTR_W, 32, instruction width
- RESET_PC, 0, first fetch address after reset
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset, sampled on rising clk
- imem_req  out  1  fetch request valid
- imem_addr  out  PC_W  byte address of the outstanding request
- imem_ready  in  1  memory returns data this cycle; handshake = imem_req & imem_ready at posedge
- imem_rdata  in  INSTR_W  instruction word, valid when imem_ready=1
- stall  in  1  decode cannot accept; hold id_* outputs
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  PC_W  target address, valid with redirect
- id_valid  out  1  id_instr / id_pc4 hold a real instruction
- id_instr  out  INSTR_W  instruction to decode (0 = nop when invalid)
- id_pc4  out  PC_W  address of id_instr + 4

## Operation
- Reset values: state=FETCH, imem_addr=RESET_PC, imem_req=0 during the reset cycle, id_valid=0, id_instr=0, id_pc4=0, skid buffer empty.
- imem_req=1 in FETCH and DROP, 0 in HOLD and while reset=1. imem_addr is held stable until the handshake completes.
- FETCH, handshake, no redirect:
  - If stall=0 or id_valid=0: load id_instr=imem_rdata, id_pc4=imem_addr+4, id_valid=1; imem_addr<=imem_addr+4; stay in FETCH.
  - If stall=1 and id_valid=1: write rdata/pc4 into the skid buffer, imem_addr<=imem_addr+4, go to HOLD.
- FETCH, no handshake: if stall=0, set id_valid<=0 and id_instr<=0 (bubble); if stall=1, hold id_*.
- HOLD: id_* held while stall=1. When stall=0, move the skid buffer into id_* (id_valid=1), empty the buffer, go to FETCH.
- Redirect (highest priority; wins over stall and over a same-cycle handshake):
  - id_valid<=0, id_instr<=0; skid buffer discarded.
  - In FETCH with handshake, or in HOLD: imem_addr<=redirect_pc; go to FETCH.
  - In FETCH without handshake: the outstanding request must complete, so latch pend_pc<=redirect_pc and go to DROP.
- DROP: imem_addr held. A redirect here overwrites pend_pc. On handshake, rdata is discarded, imem_addr<=pend_pc, go to FETCH. id_valid stays 0.
- Arithmetic: PC+4 is modulo 2^PC_W (0x1FC+4 -> 0x000). Bits [1:0] of redirect_pc are passed through unchecked.
- Reset asserted mid-transaction (any state) returns to reset values next edge; an outstanding memory request is abandoned.

## Timing
- Zero-wait memory (imem_ready tied 1): throughput is 1 instruction/cycle. The handshake at edge N makes id_valid=1 after edge N.
- First request: the first cycle with reset=0, addr=RESET_PC.
- Redirect at edge N: id_valid=0 after N. A new-target request is issued in cycle N+1 if the redirect arrived in FETCH-with-handshake or in HOLD; otherwise it follows the DROP handshake.
- Stall release from HOLD at edge N: buffered instruction valid after N; the next request is issued in cycle N+1.
- No combinational path from imem_rdata to id_*; stall/redirect to imem_req/imem_addr is combinational only through state (registered).

## Structure
- Shared package pipe_pkg: PC_W, INSTR_W, NOP_INSTR=32'h0, and fetch_state_t enum {FETCH, HOLD, DROP}.
- Sub-module fetch_skid_buf: one-entry buffer (instr, pc4, full flag) with load/unload/clear.
- All remaining logic (FSM, address register, pend_pc, id_* registers) lives in fetch_unit.

## Test plan
- Reset, imem_ready=1, rdata=addr-tagged words: imem_addr 0,4,8,…; id_pc4 4,8,12 on consecutive cycles; id_valid=1 from the second cycle onward.
- 2-wait-state memory: one id_valid pulse every 3 cycles; id_valid=0 and id_instr=0 in between; imem_addr stable during each wait.
- stall=1 for 3 cycles with a handshake in the first: enters HOLD, imem_req=0, id_instr unchanged; stall drop -> buffered word (addr 0x008) appears, fetch resumes at 0x00C.
- redirect=1, redirect_pc=0x040 while a request to 0x010 is waiting: DROP; the 0x010 data is discarded; next request 0x040; no id_valid between.
- redirect and stall asserted together in HOLD: flush wins, id_valid=0, next imem_addr=redirect_pc.
- Wrap: redirect_pc=0x1FC, zero-wait -> id_pc4=0x000, next imem_addr=0x000; reset asserted in DROP -> imem_addr=RESET_PC and id_valid=0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, nop encoding, fetch FSM states.
// Imported by the fetch stage and its skid buffer.
package pipe_pkg;

    localparam int PC_W    = 9;
    localparam int INSTR_W = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word while decode is stalled.
// Ports: clk/reset, load_i/unload_i/clear_i controls, instr_i/pc4_i in, full_o/instr_o/pc4_o out.
module fetch_skid_buf #(
    parameter int PC_W    = 9,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               unload_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc4_i,
    output logic               full_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc4_o
);

    logic               full_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc4_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q  <= 1'b0;
            instr_q <= '0;
            pc4_q   <= '0;
        end else if (clear_i || unload_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q  <= 1'b1;
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
        end
    end

    assign full_o  = full_q;
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with imem, feeds decode.
// Ports: clk/reset; imem_req/addr/ready/rdata; stall, redirect/redirect_pc; id_valid/instr/pc4.
module fetch_unit #(
    parameter int              PC_W     = pipe_pkg::PC_W,
    parameter int              INSTR_W  = pipe_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc4
);

    import pipe_pkg::*;

    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

    fetch_state_t state_q, state_d;

    logic [PC_W-1:0]    addr_q, addr_d;
    logic [PC_W-1:0]    pend_q, pend_d;
    logic               vld_q, vld_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc4_q, pc4_d;

    logic               sb_load, sb_unload, sb_clear;
    logic               sb_full;
    logic [INSTR_W-1:0] sb_instr;
    logic [PC_W-1:0]    sb_pc4;

    logic               hs;
    logic [PC_W-1:0]    addr_inc;

    // HOLD issues nothing; DROP keeps the abandoned request alive until it completes.
    assign imem_req  = !reset && (state_q != HOLD);
    assign imem_addr = addr_q;
    assign hs        = imem_req && imem_ready;
    assign addr_inc  = addr_q + PC_W'(4);

    fetch_skid_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load_i   (sb_load),
        .unload_i (sb_unload),
        .clear_i  (sb_clear),
        .instr_i  (imem_rdata),
        .pc4_i    (addr_inc),
        .full_o   (sb_full),
        .instr_o  (sb_instr),
        .pc4_o    (sb_pc4)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pend_d    = pend_q;
        vld_d     = vld_q;
        instr_d   = instr_q;
        pc4_d     = pc4_q;
        sb_load   = 1'b0;
        sb_unload = 1'b0;
        sb_clear  = 1'b0;

        if (redirect) begin
            vld_d    = 1'b0;
            instr_d  = NOP;
            sb_clear = 1'b1;
        end

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (hs) begin
                        addr_d = redirect_pc;
                    end else begin
                        pend_d  = redirect_pc;
                        state_d = DROP;
                    end
                end else if (hs) begin
                    addr_d = addr_inc;
                    if (!stall || !vld_q) begin
                        vld_d   = 1'b1;
                        instr_d = imem_rdata;
                        pc4_d   = addr_inc;
                    end else begin
                        sb_load = 1'b1;
                        state_d = HOLD;
                    end
                end else if (!stall) begin
                    vld_d   = 1'b0;
                    instr_d = NOP;
                end
            end
            HOLD: begin
                if (redirect) begin
                    addr_d  = redirect_pc;
                    state_d = FETCH;
                end else if (!stall) begin
                    vld_d     = sb_full;
                    instr_d   = sb_instr;
                    pc4_d     = sb_pc4;
                    sb_unload = 1'b1;
                    state_d   = FETCH;
                end
            end
            DROP: begin
                if (redirect) begin
                    pend_d = redirect_pc;
                end
                // Newest redirect target wins if it lands on the draining handshake.
                if (hs) begin
                    addr_d  = redirect ? redirect_pc : pend_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            addr_q  <= RESET_PC;
            pend_q  <= RESET_PC;
            vld_q   <= 1'b0;
            instr_q <= NOP;
            pc4_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            vld_q   <= vld_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign id_valid = vld_q;
    assign id_instr = instr_q;
    assign id_pc4   = pc4_q;

endmodule
